// File: rtl/stat_seq_pkg.sv
// Shared types and bit-level helpers for the stat_seq keyed mixing pipeline.
// Helpers work on a MAX_W-wide container; callers pass the live width.
package stat_seq_pkg;

  localparam int MAX_W = 256;

  typedef logic [MAX_W-1:0] word_t;
  typedef logic [7:0]       idx_t;

  typedef enum logic [1:0] {
    BYPASS  = 2'd0,
    MIX     = 2'd1,
    MIX_INV = 2'd2,
    RSVD    = 2'd3
  } mode_e;

  function automatic word_t rotl(input word_t x, input int s, input int w);
    word_t y;
    y = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) y[idx_t'((i + s) % w)] = x[idx_t'(i)];
    return y;
  endfunction

  function automatic word_t mix(input word_t x, input word_t k, input int w);
    word_t y;
    y = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w)
        y[idx_t'(i)] = x[idx_t'(i)]
                     ^ (x[idx_t'((i + 1) % w)] & ~x[idx_t'((i + 3) % w)])
                     ^ k[idx_t'(i)];
    return y;
  endfunction

endpackage

// File: rtl/stat_seq_stage.sv
// One pipeline stage: valid/data/mode registers fed by the keyed mix of the
// previous stage's word, shifting only when the global advance is high.
module stat_seq_stage
  import stat_seq_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] K     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output mode_e            mode_o
);

  logic             vld_q;
  logic [WIDTH-1:0] data_q, data_d;
  mode_e            mode_q;
  word_t            key_sel;

  // RSVD falls through to the plain-key mix
  always_comb begin
    key_sel = (mode_i == MIX_INV) ? word_t'(~K) : word_t'(K);
    data_d  = (mode_i == BYPASS) ? data_i
                                 : WIDTH'(mix(word_t'(data_i), key_sel, WIDTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      mode_q <= BYPASS;
    end else if (adv_i) begin
      vld_q  <= vld_i;
      data_q <= data_d;
      mode_q <= mode_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign mode_o = mode_q;

endmodule

// File: rtl/stat_seq_pipe.sv
// STAGES-deep keyed mixing pipeline with global stall and handshake counter.
// Define STAT_SEQ_MISR_EN to add the output MISR (sig_clear / signature).
module stat_seq_pipe
  import stat_seq_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               STAGES = 3,
  parameter logic [WIDTH-1:0] KEY    = {(WIDTH/2){2'b01}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      txn_count
`ifdef STAT_SEQ_MISR_EN
  ,
  input  logic             sig_clear,
  output logic [WIDTH-1:0] signature
`endif
);

  logic                    adv;
  logic                    out_hs;
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  mode_e                   mode_pipe [0:STAGES];
  logic [15:0]             txn_q;
  logic                    unused_mode;

  assign adv    = !out_valid || out_ready;
  assign out_hs = out_valid && out_ready;

  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = in_data;
  assign mode_pipe[0] = mode_e'(in_mode);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam logic [WIDTH-1:0] KS = WIDTH'(rotl(word_t'(KEY), s % WIDTH, WIDTH));
    stat_seq_stage #(.WIDTH(WIDTH), .K(KS)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_i  (adv),
      .vld_i  (vld_pipe[s]),
      .data_i (data_pipe[s]),
      .mode_i (mode_pipe[s]),
      .vld_o  (vld_pipe[s+1]),
      .data_o (data_pipe[s+1]),
      .mode_o (mode_pipe[s+1])
    );
  end

  // the last stage's mode has no downstream consumer
  assign unused_mode = ^mode_pipe[STAGES];

  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      txn_q <= '0;
    else if (out_hs) txn_q <= txn_q + 16'd1;
  end

  assign txn_count = txn_q;

`ifdef STAT_SEQ_MISR_EN
  logic [WIDTH-1:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sig_q <= '0;
    else if (sig_clear) sig_q <= '0;
    else if (out_hs)    sig_q <= WIDTH'(rotl(word_t'(sig_q), 1, WIDTH)) ^ out_data;
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_stat_seq_pipe.sv
// Directed bench for stat_seq_pipe: a 1-stage and a 3-stage instance at
// WIDTH=8, KEY=8'h55, each watched by a queue-based reference model.
module tb_stat_seq_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [7:0] a_in_data = 8'h00, a_out_data;
  logic [1:0] a_in_mode = 2'd0;
  logic [15:0] a_txn;
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [7:0] b_in_data = 8'h00, b_out_data;
  logic [1:0] b_in_mode = 2'd0;
  logic [15:0] b_txn;
`ifdef STAT_SEQ_MISR_EN
  logic       a_sig_clear = 1'b0, b_sig_clear = 1'b0;
  logic [7:0] a_sig, b_sig;
`endif

  stat_seq_pipe #(.WIDTH(8), .STAGES(1), .KEY(8'h55)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .txn_count(a_txn)
`ifdef STAT_SEQ_MISR_EN
    , .sig_clear(a_sig_clear), .signature(a_sig)
`endif
  );

  stat_seq_pipe #(.WIDTH(8), .STAGES(3), .KEY(8'h55)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .txn_count(b_txn)
`ifdef STAT_SEQ_MISR_EN
    , .sig_clear(b_sig_clear), .signature(b_sig)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // y = x ^ (x rotated right 1 & ~x rotated right 3) ^ k, vector form
  function automatic logic [7:0] mix8(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] x1, x3;
    x1 = {x[0], x[7:1]};
    x3 = {x[2:0], x[7:3]};
    return x ^ (x1 & ~x3) ^ k;
  endfunction

  function automatic logic [7:0] expect_out(input logic [7:0] x, input logic [1:0] m, input int stages);
    logic [7:0] y, k;
    y = x;
    for (int s = 0; s < stages; s++) begin
      k = rot8(8'h55, s % 8);
      if (m == 2'd2)      y = mix8(y, ~k);
      else if (m != 2'd0) y = mix8(y, k);
    end
    return y;
  endfunction

  logic [7:0] exp_q_a [$];
  logic [7:0] exp_q_b [$];

  // reference monitor, instance A (1 stage)
  initial begin
    logic [15:0] cnt;
    logic [7:0]  sig_m;
    cnt = '0; sig_m = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q_a.delete(); cnt = '0; sig_m = '0;
      end else begin
        chk1("a_in_ready", a_in_ready, !a_out_valid || a_out_ready);
        chk16("a_txn", a_txn, cnt);
`ifdef STAT_SEQ_MISR_EN
        chk8("a_sig", a_sig, sig_m);
        if (a_sig_clear)                    sig_m = 8'h00;
        else if (a_out_valid && a_out_ready) sig_m = rot8(sig_m, 1) ^ a_out_data;
`endif
        if (a_out_valid && a_out_ready) begin
          if (exp_q_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_spurious_out: got %02h expected none", a_out_data);
          end else chk8("a_out", a_out_data, exp_q_a.pop_front());
          cnt++;
        end
        if (a_in_valid && a_in_ready) exp_q_a.push_back(expect_out(a_in_data, a_in_mode, 1));
      end
    end
  end

  // reference monitor, instance B (3 stages), including stall stability
  initial begin
    logic [15:0] cnt;
    logic [7:0]  sig_m, hold;
    logic        stalled;
    cnt = '0; sig_m = '0; hold = '0; stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q_b.delete(); cnt = '0; sig_m = '0; stalled = 1'b0;
      end else begin
        chk1("b_in_ready", b_in_ready, !b_out_valid || b_out_ready);
        chk16("b_txn", b_txn, cnt);
        if (stalled) begin
          chk1("b_hold_valid", b_out_valid, 1'b1);
          chk8("b_hold_data", b_out_data, hold);
        end
`ifdef STAT_SEQ_MISR_EN
        chk8("b_sig", b_sig, sig_m);
        if (b_sig_clear)                    sig_m = 8'h00;
        else if (b_out_valid && b_out_ready) sig_m = rot8(sig_m, 1) ^ b_out_data;
`endif
        if (b_out_valid && b_out_ready) begin
          if (exp_q_b.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL b_spurious_out: got %02h expected none", b_out_data);
          end else chk8("b_out", b_out_data, exp_q_b.pop_front());
          cnt++;
        end
        if (b_in_valid && b_in_ready) exp_q_b.push_back(expect_out(b_in_data, b_in_mode, 3));
        stalled = b_out_valid && !b_out_ready;
        hold    = b_out_data;
      end
    end
  end

  task automatic send_a(input logic [7:0] d, input logic [1:0] m, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
    @(negedge clk);
    chk1({name, "_pre"}, a_out_valid, 1'b0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk1({name, "_vld"}, a_out_valid, 1'b1);
    chk8(name, a_out_data, exp);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("rst_a_in_ready", a_in_ready, 1'b1);
    chk1("rst_b_in_ready", b_in_ready, 1'b1);
    chk1("rst_b_out_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] words [10] = '{8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, c;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_a_out_valid", a_out_valid, 1'b0);
    chk1("reset_b_out_valid", b_out_valid, 1'b0);
    chk16("reset_a_txn", a_txn, 16'h0000);
    chk1("reset_b_in_ready", b_in_ready, 1'b1);

    // single-stage literal vectors
    send_a(8'hA5, 2'd0, 8'hA5, "bypass_a5");
    send_a(8'h00, 2'd1, 8'h55, "mix_00");
    send_a(8'hFF, 2'd2, 8'h55, "mixinv_ff");
    send_a(8'hFF, 2'd1, 8'hAA, "mix_ff");
    send_a(8'h00, 2'd3, 8'h55, "rsvd_00");
    send_a(8'hFF, 2'd3, 8'hAA, "rsvd_ff");
    send_a(8'h3C, 2'd2, expect_out(8'h3C, 2'd2, 1), "mixinv_3c");

    // 10 back-to-back words into 3 stages with a 4-cycle output stall
    i = 0; c = 0;
    while (i < 10 && c < 100) begin
      @(posedge clk); #1;
      b_out_ready = !(c >= 5 && c < 9);
      b_in_valid  = 1'b1;
      b_in_data   = words[i];
      b_in_mode   = 2'(i % 4);
      @(negedge clk);
      if (!b_out_ready) chk1("b_stall_in_ready", b_in_ready, 1'b0);
      if (b_in_ready) i++;
      c++;
    end
    if (i < 10) begin
      n_tests++; n_fail++;
      $display("FAIL b_stream_accept: got %0d words expected 10", i);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int k = 0; k < 50 && (exp_q_b.size() != 0 || b_out_valid); k++) @(negedge clk);
    chk16("b_drained", 16'(exp_q_b.size()), 16'd0);
    chk16("b_txn_10", b_txn, 16'd10);

    // reset with three words in flight, then latency of a fresh word
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_data = words[j + 3]; b_in_mode = 2'd1;
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    pulse_reset();
    @(negedge clk);
    chk1("post_rst_b_out_valid", b_out_valid, 1'b0);
    chk16("post_rst_b_txn", b_txn, 16'h0000);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = 8'h3C; b_in_mode = 2'd1;
    @(negedge clk);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1("b_latency", b_out_valid, (k == 3));
    end
    repeat (2) @(negedge clk);

`ifdef STAT_SEQ_MISR_EN
    @(posedge clk); #1 a_sig_clear = 1'b1;
    @(posedge clk); #1 a_sig_clear = 1'b0;
    @(negedge clk);
    chk8("sig_cleared", a_sig, 8'h00);
    send_a(8'h55, 2'd0, 8'h55, "misr_w1");
    @(posedge clk); @(negedge clk);
    chk8("sig_55", a_sig, 8'h55);
    send_a(8'h55, 2'd0, 8'h55, "misr_w2");
    @(posedge clk); @(negedge clk);
    chk8("sig_ff", a_sig, 8'hFF);
    send_a(8'h12, 2'd0, 8'h12, "misr_w3");
    a_sig_clear = 1'b1;
    @(posedge clk); #1 a_sig_clear = 1'b0;
    @(negedge clk);
    chk8("sig_clear_prio", a_sig, 8'h00);
`endif

    // txn_count wrap: 16'hFFFF handshakes, then one more
    pulse_reset();
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 8'h5A; a_in_mode = 2'd1;
    repeat (65535) @(posedge clk);
    #1 a_in_valid = 1'b0;
    for (int k = 0; k < 10 && (a_out_valid || exp_q_a.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    chk16("a_txn_ffff", a_txn, 16'hFFFF);
    send_a(8'h01, 2'd0, 8'h01, "wrap_word");
    @(posedge clk); @(negedge clk);
    chk16("a_txn_wrap", a_txn, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stat_seq_pipe.md
STAT_SEQ_PIPE -- requirements
Module: stat_seq_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be even and at least 8.
REQ-002 Parameter STAGES, default 3, pipeline depth; SHALL be in the range 1..8.
REQ-003 Parameter KEY, default alternating 01 pattern (LSB=1, 'h5555_5555 at WIDTH=32), WIDTH-bit round key.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input word offered.
REQ-007 in_ready  output  1  input word accepted when in_valid && in_ready.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 in_mode  input  2  per-word mode: 0 bypass, 1 mix, 2 mix with inverted key, 3 treated as 1.
REQ-010 out_valid  output  1  result word offered.
REQ-011 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 out_data  output  WIDTH  result word.
REQ-013 txn_count  output  16  count of completed output handshakes.
REQ-014 sig_clear  input  1  synchronous signature clear; present only with STAT_SEQ_MISR_EN.
REQ-015 signature  output  WIDTH  MISR signature; present only with STAT_SEQ_MISR_EN.

Function
REQ-016 Stage s (s = 0..STAGES-1) SHALL hold a valid bit, a WIDTH-bit data register and a 2-bit mode register.
REQ-017 Round constant k_s SHALL be KEY rotated left by s bits, modulo WIDTH.
REQ-018 Mix SHALL be y[i] = x[i] ^ (x[(i+1)%WIDTH] & ~x[(i+3)%WIDTH]) ^ k[i]; mode 2 SHALL use ~k_s; mode 0 SHALL be y = x.
REQ-019 Stage 0 SHALL capture mix(in_data) with in_mode; stage s>0 SHALL capture mix(stage s-1 data) using stage s-1 mode; the mode SHALL travel with its word.
REQ-020 Global advance = !out_valid || out_ready; all stages SHALL shift only when advance is 1.
REQ-021 in_ready SHALL equal advance (combinational); out_valid, out_data SHALL be last-stage valid and data.
REQ-022 Latency SHALL be exactly STAGES cycles from input handshake to out_valid with no stall; throughput one word per cycle.
REQ-023 Bubbles SHALL propagate unchanged; no bubble collapse.
REQ-024 While out_valid && !out_ready, out_data and all stage registers SHALL hold stable.
REQ-025 in_data, in_mode SHALL be ignored when in_valid is 0; an invalid slot's data register value is don't-care.
REQ-026 txn_count SHALL increment by 1 on each output handshake and wrap 16'hFFFF -> 16'h0000.

Reset
REQ-027 On rst_n low, all valid bits, data and mode registers, txn_count and signature SHALL clear to 0 asynchronously.
REQ-028 Words in flight at reset SHALL be discarded; out_valid SHALL be 0 in the first cycle after release.
REQ-029 in_ready SHALL be 1 during and after reset (out_valid 0).

Configuration
REQ-030 Macro STAT_SEQ_MISR_EN defined: on each output handshake, signature SHALL become ROTL(signature,1) ^ out_data; sig_clear high SHALL set 0 and takes priority over the update.
REQ-031 Macro undefined: sig_clear and signature ports and MISR logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package stat_seq_pkg SHALL hold the mode enum (BYPASS, MIX, MIX_INV, RSVD), the rotate-left function and the mix function.
REQ-033 One sub-module stat_seq_stage SHALL implement one stage register plus mix, instantiated STAGES times via generate.

Verification
REQ-034 WIDTH=8, STAGES=1, KEY=8'h55: mode 0, in 8'hA5 -> out_data 8'hA5 with out_valid one cycle later.
REQ-035 Same config: mode 1, in 8'h00 -> 8'h55; mode 2, in 8'hFF -> 8'h55; mode 1, in 8'hFF -> 8'hAA; mode 3 matches mode 1.
REQ-036 STAGES=3: back-to-back 10 words, out_ready held 0 for 4 cycles mid-stream -> in_ready 0, out_data stable, all 10 words in order, none lost or duplicated.
REQ-037 Reset asserted with 3 words in flight -> out_valid 0, txn_count 0 after release; next word appears after exactly STAGES cycles.
REQ-038 Preload 16'hFFFF handshakes -> txn_count reads 16'hFFFF, one more handshake -> 16'h0000.
REQ-039 With STAT_SEQ_MISR_EN, WIDTH=8: sig_clear, then two outputs of 8'h55 -> signature 8'h55 then 8'hFF; sig_clear coincident with a handshake -> signature 8'h00.
